// File: rtl/add_16b.sv
// add_16b: registered 16-bit unsigned adder with carry-out.
// The sum is formed by four 4-bit carry-lookahead groups chained by group
// carry. Both outputs come straight from flops, so there is no combinational
// path from the operands to the outputs. A new operand pair is accepted on
// every clock; the block has no valid/ready handshake and never stalls.
module add_16b (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_A,
  input  logic [15:0] i_B,
  output logic [15:0] o_S,
  output logic        o_C
);

  // Per-bit generate and propagate terms
  logic [15:0] bit_g;
  logic [15:0] bit_p;
  // Carry into each bit position
  logic [15:0] bit_c;
  // Group generate and propagate, one pair per 4-bit group
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;
  // Group carries: grp_c[k] enters group k, grp_c[4] is the carry-out
  logic [4:0]  grp_c;
  // Combinational sum and carry feeding the output flops
  logic [15:0] sum_next;
  logic        carry_next;

  assign bit_g = i_A & i_B;
  assign bit_p = i_A ^ i_B;

  // There is no carry-in, so the chain starts at zero
  assign grp_c[0] = 1'b0;

  for (genvar k = 0; k < 4; k++) begin : g_cla_group
    logic [3:0] g;
    logic [3:0] p;
    logic       cin;

    assign g   = bit_g[4*k +: 4];
    assign p   = bit_p[4*k +: 4];
    assign cin = grp_c[k];

    // Lookahead carries inside the group, each written directly in terms
    // of the group carry-in rather than rippling bit to bit
    assign bit_c[4*k + 0] = cin;
    assign bit_c[4*k + 1] = g[0]
                          | (p[0] & cin);
    assign bit_c[4*k + 2] = g[1]
                          | (p[1] & g[0])
                          | (p[1] & p[0] & cin);
    assign bit_c[4*k + 3] = g[2]
                          | (p[2] & g[1])
                          | (p[2] & p[1] & g[0])
                          | (p[2] & p[1] & p[0] & cin);

    // Group terms used to form the carry into the next group
    assign grp_g[k] = g[3]
                    | (p[3] & g[2])
                    | (p[3] & p[2] & g[1])
                    | (p[3] & p[2] & p[1] & g[0]);
    assign grp_p[k] = &p;

    assign grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
  end

  assign sum_next   = bit_p ^ bit_c;
  assign carry_next = grp_c[4];

  // Output register; reset wins over the addition at the same edge
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_S <= 16'h0000;
      o_C <= 1'b0;
    end else begin
      o_S <= sum_next;
      o_C <= carry_next;
    end
  end

endmodule

// File: tb/tb_add_16b.sv
// tb_add_16b: directed and random checks of add_16b against a plain
// 17-bit arithmetic reference, one operand pair per clock.
module tb_add_16b;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] s;
  logic        c;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int check_cnt = 0;

  // Expected {carry, sum} for each operand pair, oldest first
  logic [16:0] exp_q[$];

  add_16b dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_A   (a),
    .i_B   (b),
    .o_S   (s),
    .o_C   (c)
  );

  // Clock: 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: reset gives zero, otherwise the exact 17-bit sum
  function automatic logic [16:0] ref_sum(input logic [15:0] x,
                                          input logic [15:0] y,
                                          input logic        r);
    if (r) return 17'd0;
    return 17'(x) + 17'(y);
  endfunction

  // Apply one operand pair before an edge, then check just after that edge
  task automatic step(input string tag, input logic [15:0] x,
                      input logic [15:0] y, input logic r);
    logic [16:0] exp;
    logic [16:0] got;
    @(negedge clk);
    a   = x;
    b   = y;
    rst = r;
    exp_q.push_back(ref_sum(x, y, r));
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    got = {c, s};
    check_cnt++;
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: A=%h B=%h rst=%0b got C=%b S=%h expected C=%b S=%h",
             tag, x, y, r, got[16], got[15:0], exp[16], exp[15:0]);
    end
  endtask

  initial begin
    a   = 16'h0000;
    b   = 16'h0000;
    rst = 1'b1;

    // Reset for two edges with maximal operands present
    step("reset0", 16'hFFFF, 16'hFFFF, 1'b1);
    step("reset1", 16'hFFFF, 16'hFFFF, 1'b1);

    // Streaming vectors, one per cycle
    step("stream0", 16'hF7F8, 16'h7961, 1'b0);
    step("stream1", 16'hE5E1, 16'h73A3, 1'b0);
    step("stream2", 16'h3F1B, 16'h46EA, 1'b0);

    // Boundaries
    step("zero",      16'h0000, 16'h0000, 1'b0);
    step("wrap",      16'hFFFF, 16'h0001, 1'b0);
    step("max",       16'hFFFF, 16'hFFFF, 1'b0);
    step("msb_pair",  16'h8000, 16'h8000, 1'b0);
    step("msb_carry", 16'h7FFF, 16'h0001, 1'b0);

    // Carry crossing group boundaries
    step("grp0_1", 16'h000F, 16'h0001, 1'b0);
    step("grp1_2", 16'h00FF, 16'h0001, 1'b0);
    step("grp2_3", 16'h0FFF, 16'h0001, 1'b0);

    // Reset in the middle of a stream with operands held
    step("mid_pre",  16'h1234, 16'h1111, 1'b0);
    step("mid_rst",  16'h1234, 16'h1111, 1'b1);
    step("mid_post", 16'h1234, 16'h1111, 1'b0);

    // Random operand pairs, with an occasional reset mixed in
    for (int i = 0; i < 10000; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rr;
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      rr = ($urandom_range(0, 99) == 0);
      step("random", ra, rb, rr);
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
